// File: rtl/hazard_scoreboard_if.sv
// Decode <-> scoreboard interface.
//   master : Decode side, drives instruction fields and flush, observes stall/issue/busy_mask
//   slave  : scoreboard side
// Signals:
//   dec_valid, dec_dst, dec_src1, dec_src2, dec_wr_en, dec_src2_en, dec_lat, flush  (Decode -> scoreboard)
//   stall, issue, busy_mask                                                          (scoreboard -> Decode)
interface hazard_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int LAT_W = 3
);
  logic             dec_valid;
  logic [REG_W-1:0] dec_dst;
  logic [REG_W-1:0] dec_src1;
  logic [REG_W-1:0] dec_src2;
  logic             dec_wr_en;
  logic             dec_src2_en;
  logic [LAT_W-1:0] dec_lat;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [NREG-1:0]  busy_mask;

  modport master (
    output dec_valid, dec_dst, dec_src1, dec_src2, dec_wr_en, dec_src2_en, dec_lat, flush,
    input  stall, issue, busy_mask
  );

  modport slave (
    input  dec_valid, dec_dst, dec_src1, dec_src2, dec_wr_en, dec_src2_en, dec_lat, flush,
    output stall, issue, busy_mask
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard gating issue out of Decode.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; clears every countdown
//   sb     slave modport of hazard_scoreboard_if
//            stall     = dec_valid & (RAW | WAW) & ~flush   (combinational)
//            issue     = dec_valid & ~stall & ~flush        (combinational)
//            busy_mask = bit r set while cnt[r] != 0        (from registered state)
// Register 0 is hardwired zero: it has no counter and is never busy.

// One register's countdown. Priority: reset > clr > load > decrement > hold.
module hsb_cnt_cell #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             busy
);
  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int LAT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             wr_en;
    logic             src2_en;
    logic [LAT_W-1:0] lat;
  } dec_req_t;

  dec_req_t        req;
  logic [NREG-1:0] busy_vec;
  logic            raw, waw, stall, issue, issue_wr;

  assign req = '{valid:   sb.dec_valid,
                 dst:     sb.dec_dst,
                 src1:    sb.dec_src1,
                 src2:    sb.dec_src2,
                 wr_en:   sb.dec_wr_en,
                 src2_en: sb.dec_src2_en,
                 lat:     sb.dec_lat};

  // Hazards are judged on pre-issue state, so src == dst of the same
  // instruction never blocks itself.
  assign raw   = busy_vec[req.src1] | (req.src2_en & busy_vec[req.src2]);
  assign waw   = req.wr_en & busy_vec[req.dst];
  assign stall = req.valid & (raw | waw) & ~sb.flush;
  assign issue = req.valid & ~stall & ~sb.flush;

  // A load only happens when the dst counter is already zero (WAW gate),
  // so load and decrement never collide in a cell.
  assign issue_wr = issue & req.wr_en;

  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    hsb_cnt_cell #(.LAT_W(LAT_W)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .clr      (sb.flush),
      .load     (issue_wr && (req.dst == REG_W'(r))),
      .load_val (req.lat),
      .busy     (busy_vec[r])
    );
  end

  assign sb.stall     = stall;
  assign sb.issue     = issue;
  assign sb.busy_mask = busy_vec;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int NREG = 32, REG_W = 5, LAT_W = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .REG_W(REG_W), .LAT_W(LAT_W)) sbif ();

  hazard_scoreboard #(.NREG(NREG), .REG_W(REG_W), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, leave inputs settled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one decode slot; check happens after a settle delay
  task automatic drv(input logic v, input int dst, input int s1, input int s2,
                     input logic wr, input logic s2en, input int lat);
    sbif.dec_valid   = v;
    sbif.dec_dst     = REG_W'(dst);
    sbif.dec_src1    = REG_W'(s1);
    sbif.dec_src2    = REG_W'(s2);
    sbif.dec_wr_en   = wr;
    sbif.dec_src2_en = s2en;
    sbif.dec_lat     = LAT_W'(lat);
    #1;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    repeat (n) tick();
  endtask

  initial begin
    reset      = 1'b1;
    sbif.flush = 1'b0;
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    #2;

    // 1. reset, then lat=0 write tracks nothing
    repeat (2) tick();
    chk("rst_busy", sbif.busy_mask, 32'h0);
    chk("rst_stall", sbif.stall, 1'b0);
    reset = 1'b0;
    drv(1'b1, 3, 0, 0, 1'b1, 1'b0, 0);
    chk("t1_issue", sbif.issue, 1'b1);
    tick();
    chk("t1_busy", sbif.busy_mask, 32'h0);

    // 2. RAW on r3, lat 2 -> exactly 2 stall cycles
    drv(1'b1, 3, 0, 0, 1'b1, 1'b0, 2);
    chk("t2_prod", sbif.issue, 1'b1);
    tick();
    drv(1'b1, 0, 3, 0, 1'b0, 1'b0, 0);
    chk("t2_stall0", sbif.stall, 1'b1);
    chk("t2_busy0", sbif.busy_mask[3], 1'b1);
    chk("t2_iss0", sbif.issue, 1'b0);
    tick(); #1;
    chk("t2_stall1", sbif.stall, 1'b1);
    chk("t2_busy1", sbif.busy_mask[3], 1'b1);
    tick(); #1;
    chk("t2_stall2", sbif.stall, 1'b0);
    chk("t2_iss2", sbif.issue, 1'b1);
    chk("t2_busy2", sbif.busy_mask[3], 1'b0);
    tick();

    // 3. src2 only matters when src2_en
    drv(1'b1, 5, 0, 0, 1'b1, 1'b0, 7);
    chk("t3_prod", sbif.issue, 1'b1);
    tick();
    drv(1'b1, 0, 1, 5, 1'b0, 1'b0, 0);
    chk("t3_noen_iss", sbif.issue, 1'b1);
    chk("t3_noen_stall", sbif.stall, 1'b0);
    tick();
    drv(1'b1, 0, 1, 5, 1'b0, 1'b1, 0);
    chk("t3_en_stall", sbif.stall, 1'b1);
    tick();                                   // cnt[5] = 5
    drv(1'b0, 0, 5, 5, 1'b1, 1'b1, 0);
    chk("t3_nv_stall", sbif.stall, 1'b0);
    chk("t3_nv_iss", sbif.issue, 1'b0);
    idle(4);                                  // cnt[5] = 1
    chk("t3_busy_last", sbif.busy_mask, 32'h20);
    tick();
    chk("t3_drained", sbif.busy_mask, 32'h0);

    // 4. WAW on r4, lat 3 -> 3 stall cycles then reload with lat 5
    drv(1'b1, 4, 0, 0, 1'b1, 1'b0, 3);
    tick();
    drv(1'b1, 4, 0, 0, 1'b1, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_stall%0d", i), sbif.stall, 1'b1);
      tick(); #1;
    end
    chk("t4_iss", sbif.issue, 1'b1);
    tick();
    chk("t4_reload", sbif.busy_mask, 32'h10);
    idle(4);
    chk("t4_busy_last", sbif.busy_mask, 32'h10);
    tick();
    chk("t4_drained", sbif.busy_mask, 32'h0);

    // 5. dst = 0 never tracked
    drv(1'b1, 0, 0, 0, 1'b1, 1'b0, 7);
    chk("t5_iss", sbif.issue, 1'b1);
    tick();
    chk("t5_busy", sbif.busy_mask, 32'h0);
    drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 0);
    chk("t5_dep_stall", sbif.stall, 1'b0);
    chk("t5_dep_iss", sbif.issue, 1'b1);
    tick();

    // self-dependency: src1 == dst, idle reg -> issues
    drv(1'b1, 6, 6, 0, 1'b1, 1'b0, 2);
    chk("self_iss", sbif.issue, 1'b1);
    tick();
    chk("self_stall", sbif.stall, 1'b1);
    idle(2);
    chk("self_drained", sbif.busy_mask, 32'h0);

    // 6a. flush drops dependent (which also writes r10) and clears r9
    drv(1'b1, 9, 0, 0, 1'b1, 1'b0, 6);
    tick();
    idle(1);
    chk("t6_busy_pre", sbif.busy_mask, 32'h200);
    sbif.flush = 1'b1;
    drv(1'b1, 10, 9, 0, 1'b1, 1'b0, 3);
    chk("t6f_iss", sbif.issue, 1'b0);
    chk("t6f_stall", sbif.stall, 1'b0);
    tick();
    sbif.flush = 1'b0;
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    chk("t6f_busy", sbif.busy_mask, 32'h0);

    // 6b. same with reset mid-countdown
    drv(1'b1, 9, 0, 0, 1'b1, 1'b0, 6);
    tick();
    idle(1);
    reset = 1'b1;
    drv(1'b1, 10, 9, 0, 1'b1, 1'b0, 3);
    tick();
    reset = 1'b0;
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    chk("t6r_busy", sbif.busy_mask, 32'h0);
    drv(1'b1, 0, 9, 0, 1'b0, 1'b0, 0);
    chk("t6r_stall", sbif.stall, 1'b0);
    chk("t6r_iss", sbif.issue, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
